// File: rtl/imem_loader_if.sv
// Boot-stream and instruction-memory write port bundle for the program loader.
// master = loader side, slave = stream source / memory / status observer.
interface imem_loader_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [1:0]        err_code;
  logic [15:0]       bytes_loaded;

  modport master (
    input  start, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata,
    output cpu_hold, busy, done, error, err_code, bytes_loaded
  );

  modport slave (
    output start, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata,
    input  cpu_hold, busy, done, error, err_code, bytes_loaded
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory.
// Latency: each payload byte is written one cycle after it is accepted.
// Backpressure: in_ready is high in every loading state; bubbles simply hold state.
module imem_loader #(
  parameter int MEM_BYTES = 109,
  parameter int ADDR_W    = 32
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR
  } state_t;

  state_t            state, state_nxt;
  logic              loading;
  logic              accept;
  logic [15:0]       hdr_len;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [15:0]       cnt;
  logic [7:0]        csum;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              done;
  logic              error;
  logic [1:0]        err_code;

  always_comb begin
    state_nxt = state;
    loading   = (state == LEN_LO) || (state == LEN_HI) ||
                (state == DATA)   || (state == CSUM);
    accept    = bus.in_valid && loading;
    hdr_len   = {bus.in_data, len_lo};
    case (state)
      IDLE, DONE, ERROR: if (bus.start) state_nxt = LEN_LO;
      LEN_LO:            if (accept) state_nxt = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if (hdr_len > 16'(MEM_BYTES)) state_nxt = ERROR;
          else if (hdr_len == 16'd0)    state_nxt = CSUM;
          else                          state_nxt = DATA;
        end
      end
      // cnt counts bytes already taken, so cnt+1 == len marks the final payload byte
      DATA:    if (accept && (cnt + 16'd1 == len)) state_nxt = CSUM;
      CSUM:    if (accept) state_nxt = (bus.in_data == csum) ? DONE : ERROR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      len_lo    <= 8'd0;
      len       <= 16'd0;
      cnt       <= 16'd0;
      csum      <= 8'd0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'd0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      state  <= state_nxt;
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (bus.start) begin
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= 2'b00;
            cnt      <= 16'd0;
            csum     <= 8'd0;
          end
        end
        LEN_LO: if (accept) len_lo <= bus.in_data;
        LEN_HI: begin
          if (accept) begin
            len <= hdr_len;
            if (hdr_len > 16'(MEM_BYTES)) begin
              error    <= 1'b1;
              err_code <= 2'b01;
            end
          end
        end
        DATA: begin
          if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= ADDR_W'(cnt);
            mem_wdata <= bus.in_data;
            cnt       <= cnt + 16'd1;
            csum      <= csum ^ bus.in_data;
          end
        end
        CSUM: begin
          if (accept) begin
            if (bus.in_data == csum) begin
              done <= 1'b1;
            end else begin
              error    <= 1'b1;
              err_code <= 2'b10;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready     = loading;
  assign bus.busy         = loading;
  assign bus.cpu_hold     = loading;
  assign bus.mem_we       = mem_we;
  assign bus.mem_addr     = mem_addr;
  assign bus.mem_wdata    = mem_wdata;
  assign bus.done         = done;
  assign bus.error        = error;
  assign bus.err_code     = err_code;
  assign bus.bytes_loaded = cnt;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes are queued as bytes are driven
// and popped by a write monitor; status outputs are checked after each load.
module tb_imem_loader;
  localparam int MEM_BYTES = 109;
  localparam int ADDR_W    = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;
  int   writes = 0;
  logic [39:0] exp_q[$];

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Write monitor: every strobe must match the oldest queued write.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      logic [39:0] e;
      writes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", bus.mem_addr, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", bus.mem_addr, e[39:8]);
        chk("wr_data", 32'(bus.mem_wdata), 32'(e[7:0]));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    idle(1);
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic st);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.start    = st;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        return;
      end
    end
    chk("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic load(input logic [7:0] p[$], input logic [7:0] cs, input bit bubbles);
    int n;
    n = p.size();
    pulse_start();
    send(8'(n), 1'b0);
    send(8'(n >> 8), 1'b0);
    for (int i = 0; i < n; i++) begin
      if (bubbles) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_data = 8'($urandom);
          idle(1);
        end
      end
      exp_q.push_back({32'(i), p[i]});
      send(p[i], bubbles && (i == 20 || i == 60));
    end
    send(cs, 1'b0);
  endtask

  task automatic status(input logic d, input logic e, input logic [1:0] c,
                        input int bl, input logic hold);
    chk("done",         32'(bus.done),         32'(d));
    chk("error",        32'(bus.error),        32'(e));
    chk("err_code",     32'(bus.err_code),     32'(c));
    chk("bytes_loaded", 32'(bus.bytes_loaded), 32'(bl));
    chk("cpu_hold",     32'(bus.cpu_hold),     32'(hold));
    chk("busy",         32'(bus.busy),         32'(hold));
    chk("in_ready",     32'(bus.in_ready),     32'(hold));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] p[$];
    logic [7:0] x;

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    idle(2);
    status(1'b0, 1'b0, 2'b00, 0, 1'b0);
    chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
    chk("rst_mem_addr",  bus.mem_addr,       32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    reset = 1'b0;
    idle(3);

    // Basic 4-byte load
    p = '{8'h33, 8'h03, 8'h94, 8'h00};
    load(p, 8'hA4, 1'b0);
    idle(2);
    status(1'b1, 1'b0, 2'b00, 4, 1'b0);

    // Oversize length is rejected before any write; later bytes are ignored
    pulse_start();
    send(8'h6E, 1'b0);
    send(8'h00, 1'b0);
    idle(2);
    status(1'b0, 1'b1, 2'b01, 0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    idle(3);
    bus.in_valid = 1'b0;
    status(1'b0, 1'b1, 2'b01, 0, 1'b0);

    // Checksum mismatch: writes persist, error latched
    p = '{8'h13, 8'h85};
    load(p, 8'h00, 1'b0);
    idle(2);
    status(1'b0, 1'b1, 2'b10, 2, 1'b0);

    // Zero-length program
    p.delete();
    load(p, 8'h00, 1'b0);
    idle(2);
    status(1'b1, 1'b0, 2'b00, 0, 1'b0);

    // Reset mid-load, just as the third payload write is being presented
    pulse_start();
    send(8'h04, 1'b0);
    send(8'h00, 1'b0);
    exp_q.push_back({32'd0, 8'hAA});
    send(8'hAA, 1'b0);
    exp_q.push_back({32'd1, 8'hBB});
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    status(1'b0, 1'b0, 2'b00, 0, 1'b0);
    chk("arst_mem_we",    32'(bus.mem_we),    32'd0);
    chk("arst_mem_addr",  bus.mem_addr,       32'd0);
    chk("arst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    idle(1);
    reset = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    idle(4);
    bus.in_valid = 1'b0;
    status(1'b0, 1'b0, 2'b00, 0, 1'b0);
    p = '{8'h01, 8'h02, 8'h04, 8'h08};
    load(p, 8'h0F, 1'b0);
    idle(2);
    status(1'b1, 1'b0, 2'b00, 4, 1'b0);

    // Full-depth load with random bubbles and ignored start pulses
    p.delete();
    x = 8'h00;
    for (int i = 0; i < MEM_BYTES; i++) begin
      p.push_back(8'($urandom));
      x = x ^ p[i];
    end
    writes = 0;
    load(p, x, 1'b1);
    idle(2);
    chk("write_count", 32'(writes), 32'(MEM_BYTES));
    status(1'b1, 1'b0, 2'b00, MEM_BYTES, 1'b0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MEM_BYTES, 109, instruction memory depth in bytes; legal load length is 0..MEM_BYTES.
REQ-002 Parameter ADDR_W, 32, width of mem_addr; matches the program-counter byte address width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse requesting a new program load.
REQ-006 in_valid  input  1  in_data holds a valid stream byte.
REQ-007 in_data  input  8  stream byte.
REQ-008 in_ready  output  1  loader accepts in_data this cycle.
REQ-009 mem_we  output  1  byte write strobe to the instruction memory write port.
REQ-010 mem_addr  output  ADDR_W  byte address of the write.
REQ-011 mem_wdata  output  8  byte written.
REQ-012 cpu_hold  output  1  holds the CPU/PC in reset while a load is in progress.
REQ-013 busy  output  1  load in progress.
REQ-014 done  output  1  sticky; last load completed with good checksum.
REQ-015 error  output  1  sticky; last load failed.
REQ-016 err_code  output  2  00 none, 01 length > MEM_BYTES, 10 checksum mismatch.
REQ-017 bytes_loaded  output  16  payload bytes written in the current/last load.

Function
REQ-018 Stream format: LEN_LO, LEN_HI (16-bit little-endian length N), N payload bytes, one checksum byte equal to XOR of all payload bytes.
REQ-019 A byte is accepted only in a cycle where in_valid and in_ready are both 1.
REQ-020 States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR.
REQ-021 in_ready is 1 in LEN_LO, LEN_HI, DATA and CSUM, and 0 in IDLE, DONE and ERROR.
REQ-022 A start in IDLE, DONE or ERROR moves to LEN_LO next cycle and clears done, error, err_code, bytes_loaded and the running checksum; start in any other state is ignored.
REQ-023 LEN_LO on accept -> LEN_HI.
REQ-024 LEN_HI on accept: N > MEM_BYTES -> ERROR with err_code 01; N == 0 -> CSUM; otherwise -> DATA.
REQ-025 Each DATA accept writes payload byte k (k = 0..N-1) to address k, with mem_we, mem_addr = k and mem_wdata = byte registered and valid for exactly one cycle, the cycle after acceptance.
REQ-026 Each DATA accept increments bytes_loaded and XORs the byte into the running checksum; the accept of byte N-1 moves to CSUM.
REQ-027 CSUM on accept: byte == running checksum -> DONE with done=1; otherwise -> ERROR with err_code 10 and error=1.
REQ-028 Memory contents written before a checksum failure are not rolled back.
REQ-029 cpu_hold and busy are 1 exactly in LEN_LO, LEN_HI, DATA and CSUM.
REQ-030 mem_addr never exceeds MEM_BYTES-1; N == MEM_BYTES is legal and writes addresses 0..MEM_BYTES-1.
REQ-031 in_valid with in_ready low has no effect; bubbles (in_valid=0) in any loading state hold state indefinitely.
REQ-032 The loader stays in DONE or ERROR until start or reset.

Reset
REQ-033 Assertion of reset, at any time including mid-load, forces IDLE immediately (asynchronously) and drives in_ready, mem_we, cpu_hold, busy, done and error to 0, err_code to 00, and mem_addr, mem_wdata and bytes_loaded to 0.
REQ-034 After reset deassertion, no memory write occurs until a new start and a complete length header.

Verification
REQ-035 start; stream 04 00 33 03 94 00 A4 -> writes 0x33@0, 0x03@1, 0x94@2, 0x00@3, each one cycle after accept; done=1; bytes_loaded=4; cpu_hold=0 afterwards.
REQ-036 start; stream 6E 00 (N=110, MEM_BYTES=109) -> ERROR; err_code=01; no mem_we; in_ready=0.
REQ-037 start; stream 02 00 13 85 00 (correct checksum is 0x96) -> both bytes written; error=1; err_code=10; done=0.
REQ-038 start; stream 00 00 00 -> done=1; bytes_loaded=0; no mem_we.
REQ-039 Reset asserted after 3 of 4 payload bytes -> outputs immediately at reset values; a full load issued after reset completes normally.
REQ-040 in_valid toggled randomly during a 109-byte load, plus start pulses issued mid-load -> only 109 writes (addresses 0..108), start pulses ignored, done=1.
